chunked_adder: RTL and testbench

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using a registered carry between chunks. It is the sequential successor to the team's single-bit half/full adder cells: the same sum/carry arithmetic, generalised in width and in bits processed per cycle. It has valid/ready handshakes on input and output, so it can sit between streaming datapath stages.

---
 rtl/chunked_adder_pkg.sv | 26 ++
 rtl/chunked_adder_chunk_adder.sv | 34 +++
 rtl/chunked_adder.sv | 129 ++++++++++++
 tb/tb_chunked_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg
//   Shared definitions for the chunked multi-cycle adder: the control FSM
//   state encoding and elaboration-time helpers that derive the number of
//   chunks and the width of the chunk index from WIDTH and CHUNK.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; never narrower than one bit so a single-chunk
  // build still has a legal index register.
  function automatic int calc_idx_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_adder_chunk_adder.sv
// chunk_adder
//   Combinational CHUNK-bit ripple-carry adder.
//   Ports:
//     a, b   : CHUNK-bit addends
//     ci     : carry in to bit 0
//     s      : CHUNK-bit sum
//     co     : carry out of the top bit
//     c_msb  : carry into the top bit (used for signed overflow)
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    co    = c[CHUNK];
    c_msb = c[CHUNK-1];
  end

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder
//   Multi-cycle adder computing a + b + cin modulo 2^WIDTH, CHUNK bits per
//   clock with a registered carry between chunks. Valid/ready handshakes on
//   both sides; a result retiring in DONE may overlap with the capture of
//   the next operands.
//   Ports:
//     clk, rst             : clock, asynchronous active-high reset
//     in_valid / in_ready  : operand handshake (a, b, cin)
//     out_valid / out_ready: result handshake (sum, cout, ovf)
//     sum                  : a + b + cin modulo 2^WIDTH
//     cout                 : unsigned carry out of the MSB
//     ovf                  : signed overflow (carry into MSB ^ carry out)
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(WIDTH, CHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if (WIDTH <= 0 || CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $fatal(1, "chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] ch_a;
  logic [CHUNK-1:0] ch_b;
  logic [CHUNK-1:0] ch_s;
  logic             ch_co;
  logic             ch_c_msb;
  logic             accept;

  // DONE can take new operands in the same edge that retires its result.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign ch_a = a_q[idx*CHUNK +: CHUNK];
  assign ch_b = b_q[idx*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (ch_a),
    .b     (ch_b),
    .ci    (carry),
    .s     (ch_s),
    .co    (ch_co),
    .c_msb (ch_c_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          sum[idx*CHUNK +: CHUNK] <= ch_s;
          carry                   <= ch_co;
          if (idx == LAST_IDX) begin
            // Carry into the top chunk's MSB is only meaningful on the last chunk.
            cout      <= ch_co;
            ovf       <= ch_c_msb ^ ch_co;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_q   <= a;
              b_q   <= b;
              carry <= cin;
              idx   <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder
//   Directed bench for chunked_adder: a WIDTH=16/CHUNK=4 instance driven by
//   a vector table plus stall and reset sequences, and a WIDTH=CHUNK=8
//   instance driven by 1000 random back-to-back operations.
module tb_chunked_adder;

  logic clk;
  logic rst;

  // 16-bit, 4-bit chunk instance
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16, ovf16;

  // 8-bit, single chunk instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, cout8, ovf8;

  int n_cmp;
  int n_fail;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
    .cout      (cout16),
    .ovf       (ovf16)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge. Offers one operand set, waits for it to
  // be accepted, scrambles the inputs, then counts edges until out_valid.
  // Returns at #1 after the edge that raised out_valid.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, output int lat);
    int w;
    a16 = ta; b16 = tb; cin16 = tc; in_valid16 = 1'b1;
    #1;
    w = 0;
    while (!in_ready16 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) chk("accept16_timeout", 32'(w), 32'd0);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    a16 = 16'hDEAD; b16 = 16'hBEEF; cin16 = 1'b1;
    lat = 0;
    while (!out_valid16 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int w;
    logic go;
    logic [7:0] ea, eb;
    logic       ec;
    logic [8:0] full;

    n_cmp = 0;
    n_fail = 0;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0;
    in_valid8  = 1'b0; out_ready8  = 1'b1; a8  = '0; b8  = '0; cin8  = 1'b0;
    #1;
    chk("rst_out_valid16", 32'(out_valid16), 32'd0);
    chk("rst_sum16",       32'(sum16),       32'd0);
    chk("rst_cout16",      32'(cout16),      32'd0);
    chk("rst_ovf16",       32'(ovf16),       32'd0);
    chk("rst_out_valid8",  32'(out_valid8),  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready16", 32'(in_ready16), 32'd1);
    chk("rst_in_ready8",  32'(in_ready8),  32'd1);
    @(posedge clk); #1;

    // Vector table, back-to-back through the DONE/accept overlap.
    for (int i = 0; i < 8; i++) begin
      run16(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat),    32'd4);
      chk($sformatf("vec%0d_sum", i),     32'(sum16),  32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i),    32'(cout16), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i),     32'(ovf16),  32'(vecs[i].ovf));
    end

    // Stall in DONE for 10 cycles with new operands waiting.
    run16(16'h00FF, 16'h0001, 1'b0, lat);
    out_ready16 = 1'b0;
    in_valid16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0;
    #1;
    chk("stall_in_ready", 32'(in_ready16), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_state", i),
          {13'd0, out_valid16, in_ready16, cout16, sum16},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h0100});
    end
    out_ready16 = 1'b1;
    #1;
    chk("stall_release_in_ready", 32'(in_ready16), 32'd1);
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
    chk("overlap_retired", 32'(out_valid16), 32'd0);
    lat = 0;
    while (!out_valid16 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("overlap_latency", 32'(lat),   32'd4);
    chk("overlap_sum",     32'(sum16), 32'h2345);

    // Reset during the second BUSY cycle.
    in_valid16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0;
    #1;
    w = 0;
    while (!in_ready16 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid16), 32'd0);
    chk("abort_sum",       32'(sum16),       32'd0);
    chk("abort_cout",      32'(cout16),      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run16(16'h0001, 16'h0002, 1'b0, lat);
    chk("post_rst_latency", 32'(lat),   32'd4);
    chk("post_rst_sum",     32'(sum16), 32'h0003);
    chk("post_rst_cout",    32'(cout16), 32'd0);
    @(posedge clk); #1;

    // Single-chunk build: random back-to-back traffic with random out_ready.
    for (int i = 0; i < 1000; i++) begin
      ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
      a8 = ea; b8 = eb; cin8 = ec;
      w = 0;
      go = 1'b0;
      do begin
        out_ready8 = 1'($urandom_range(0, 1));
        in_valid8  = ($urandom_range(0, 3) != 0);
        #1;
        go = in_valid8 && in_ready8;
        @(posedge clk); #1;
        w++;
      end while (!go && w < 50);
      if (!go) begin
        chk("r8_accept_timeout", 32'(w), 32'd0);
        break;
      end
      // Inputs change right after acceptance; result must not follow them.
      in_valid8 = 1'b0;
      a8 = ~ea; b8 = 8'($urandom); cin8 = ~ec;
      chk("r8_busy_valid", 32'(out_valid8), 32'd0);
      @(posedge clk); #1;
      full = 9'(ea) + 9'(eb) + 9'(ec);
      chk("r8_valid",  32'(out_valid8), 32'd1);
      chk("r8_sum",    32'(sum8),  32'(full[7:0]));
      chk("r8_cout",   32'(cout8), 32'(full[8]));
      chk("r8_ovf",    32'(ovf8),  32'((ea[7] == eb[7]) && (full[7] != ea[7])));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
